// File: rtl/sram_arb_ctrl.sv
// Two-requester arbiter and sequencer for a 256Kx16 async SRAM.
// Each 32-bit access is split into a low then a high 16-bit phase.
module sram_arb_ctrl #(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 18
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_if_req,
    input  logic [31:0]       i_if_addr,
    output logic              o_if_ack,
    output logic [31:0]       o_if_rdata,
    input  logic              i_ls_req,
    input  logic              i_ls_we,
    input  logic [31:0]       i_ls_addr,
    input  logic [31:0]       i_ls_wdata,
    input  logic [3:0]        i_ls_strb,
    output logic              o_ls_ack,
    output logic [31:0]       o_ls_rdata,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_SRAM_ADDR,
    inout  wire  [15:0]       io_SRAM_DQ,
    output logic              o_SRAM_CE_N,
    output logic              o_SRAM_OE_N,
    output logic              o_SRAM_WE_N,
    output logic              o_SRAM_LB_N,
    output logic              o_SRAM_UB_N
);

    localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);
    localparam int AW = ADDR_W - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_ACK  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [AW-1:0]    r_addr;
    logic             r_we;
    logic             r_gnt_ls;
    logic             r_last_ls;
    logic [31:0]      r_wdata;
    logic [3:0]       r_strb;
    logic [15:0]      r_lo;
    logic [31:0]      r_if_rdata;
    logic [31:0]      r_ls_rdata;

    logic             w_any;
    logic             w_gnt_ls;
    logic             w_sel_we;
    logic             w_skip_lo;
    logic             w_skip_hi;
    logic             w_r_skip_hi;
    logic             w_last;
    logic             w_in_phase;
    logic             w_half;
    logic             w_dq_oe;
    logic [15:0]      w_dq_out;
    logic             w_ce_n;
    logic             w_oe_n;
    logic             w_we_n;
    logic             w_lb_n;
    logic             w_ub_n;
    logic             w_unused;

    // On contention, the requester not served last wins.
    assign w_any       = i_if_req | i_ls_req;
    assign w_gnt_ls    = i_ls_req & (~i_if_req | ~r_last_ls);
    assign w_sel_we    = w_gnt_ls & i_ls_we;
    assign w_skip_lo   = w_sel_we & (i_ls_strb[1:0] == 2'b00);
    assign w_skip_hi   = w_sel_we & (i_ls_strb[3:2] == 2'b00);
    assign w_r_skip_hi = r_we & (r_strb[3:2] == 2'b00);
    assign w_last      = (r_cnt == CNT_LAST);
    assign w_in_phase  = (r_state == S_LO) || (r_state == S_HI);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nxt;
            if (w_in_phase && (w_nxt == r_state)) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    if (!w_skip_lo) begin
                        w_nxt = S_LO;
                    end else if (!w_skip_hi) begin
                        w_nxt = S_HI;
                    end else begin
                        w_nxt = S_ACK;
                    end
                end
            end
            S_LO: begin
                if (w_last) begin
                    w_nxt = w_r_skip_hi ? S_ACK : S_HI;
                end
            end
            S_HI: begin
                if (w_last) begin
                    w_nxt = S_ACK;
                end
            end
            S_ACK: begin
                w_nxt = S_IDLE;
            end
            default: begin
                w_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_gnt_ls   <= 1'b0;
            r_last_ls  <= 1'b0;
            r_wdata    <= '0;
            r_strb     <= '0;
            r_lo       <= '0;
            r_if_rdata <= '0;
            r_ls_rdata <= '0;
        end else begin
            if ((r_state == S_IDLE) && w_any) begin
                r_gnt_ls  <= w_gnt_ls;
                r_last_ls <= w_gnt_ls;
                r_we      <= w_sel_we;
                r_wdata   <= i_ls_wdata;
                r_strb    <= i_ls_strb;
                r_addr    <= w_gnt_ls ? i_ls_addr[ADDR_W:2] : i_if_addr[ADDR_W:2];
            end
            if ((r_state == S_LO) && w_last && !r_we) begin
                r_lo <= io_SRAM_DQ;
            end
            // Result lands on the edge into ACK so it is valid with the ack pulse.
            if ((r_state == S_HI) && w_last && !r_we) begin
                if (r_gnt_ls) begin
                    r_ls_rdata <= {io_SRAM_DQ, r_lo};
                end else begin
                    r_if_rdata <= {io_SRAM_DQ, r_lo};
                end
            end
        end
    end

    always_comb begin
        w_ce_n  = 1'b1;
        w_oe_n  = 1'b1;
        w_we_n  = 1'b1;
        w_lb_n  = 1'b1;
        w_ub_n  = 1'b1;
        w_dq_oe = 1'b0;
        w_half  = 1'b0;
        unique case (r_state)
            S_LO, S_HI: begin
                w_ce_n = 1'b0;
                w_half = (r_state == S_HI);
                if (r_we) begin
                    w_dq_oe = 1'b1;
                    // WE_N rises on the last cycle so addr/data hold past it.
                    w_we_n  = w_last;
                    w_lb_n  = w_half ? ~r_strb[2] : ~r_strb[0];
                    w_ub_n  = w_half ? ~r_strb[3] : ~r_strb[1];
                end else begin
                    w_oe_n = 1'b0;
                    w_lb_n = 1'b0;
                    w_ub_n = 1'b0;
                end
            end
            default: begin
                w_ce_n = 1'b1;
            end
        endcase
    end

    assign w_dq_out    = w_half ? r_wdata[31:16] : r_wdata[15:0];
    assign io_SRAM_DQ  = w_dq_oe ? w_dq_out : 16'bz;
    assign o_SRAM_ADDR = {r_addr, w_half};
    assign o_SRAM_CE_N = w_ce_n;
    assign o_SRAM_OE_N = w_oe_n;
    assign o_SRAM_WE_N = w_we_n;
    assign o_SRAM_LB_N = w_lb_n;
    assign o_SRAM_UB_N = w_ub_n;
    assign o_if_ack    = (r_state == S_ACK) & ~r_gnt_ls;
    assign o_ls_ack    = (r_state == S_ACK) & r_gnt_ls;
    assign o_if_rdata  = r_if_rdata;
    assign o_ls_rdata  = r_ls_rdata;
    assign o_busy      = (r_state != S_IDLE);

    assign w_unused = ^{i_if_addr[31:ADDR_W+1], i_if_addr[1:0],
                        i_ls_addr[31:ADDR_W+1], i_ls_addr[1:0]};

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Scoreboard bench for sram_arb_ctrl with a behavioural SRAM model.
// A second instance covers a longer phase length.
module tb_sram_arb_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        if_req, ls_req, ls_we;
    logic [31:0] if_addr, ls_addr, ls_wdata;
    logic [3:0]  ls_strb;
    logic        if_ack, ls_ack, busy;
    logic [31:0] if_rdata, ls_rdata;
    logic [17:0] sram_addr;
    wire  [15:0] dq;
    logic        ce_n, oe_n, we_n, lb_n, ub_n;

    logic        if_req3;
    logic [31:0] if_addr3;
    logic        if_ack3, ls_ack3, busy3;
    logic [31:0] if_rdata3, ls_rdata3;
    logic [17:0] addr3;
    wire  [15:0] dq3;
    logic        ce3, oe3, we3, lb3, ub3;
    logic        ls_req3 = 1'b0;
    logic        ls_we3 = 1'b0;
    logic [31:0] ls_addr3 = 32'h0;
    logic [31:0] ls_wdata3 = 32'h0;
    logic [3:0]  ls_strb3 = 4'h0;

    sram_arb_ctrl #(.WAIT_CYCLES(1), .ADDR_W(18)) u_dut (
        .i_clk(clk), .i_rst(rst),
        .i_if_req(if_req), .i_if_addr(if_addr),
        .o_if_ack(if_ack), .o_if_rdata(if_rdata),
        .i_ls_req(ls_req), .i_ls_we(ls_we), .i_ls_addr(ls_addr),
        .i_ls_wdata(ls_wdata), .i_ls_strb(ls_strb),
        .o_ls_ack(ls_ack), .o_ls_rdata(ls_rdata), .o_busy(busy),
        .o_SRAM_ADDR(sram_addr), .io_SRAM_DQ(dq),
        .o_SRAM_CE_N(ce_n), .o_SRAM_OE_N(oe_n), .o_SRAM_WE_N(we_n),
        .o_SRAM_LB_N(lb_n), .o_SRAM_UB_N(ub_n)
    );

    sram_arb_ctrl #(.WAIT_CYCLES(3), .ADDR_W(18)) u_dut3 (
        .i_clk(clk), .i_rst(rst),
        .i_if_req(if_req3), .i_if_addr(if_addr3),
        .o_if_ack(if_ack3), .o_if_rdata(if_rdata3),
        .i_ls_req(ls_req3), .i_ls_we(ls_we3), .i_ls_addr(ls_addr3),
        .i_ls_wdata(ls_wdata3), .i_ls_strb(ls_strb3),
        .o_ls_ack(ls_ack3), .o_ls_rdata(ls_rdata3), .o_busy(busy3),
        .o_SRAM_ADDR(addr3), .io_SRAM_DQ(dq3),
        .o_SRAM_CE_N(ce3), .o_SRAM_OE_N(oe3), .o_SRAM_WE_N(we3),
        .o_SRAM_LB_N(lb3), .o_SRAM_UB_N(ub3)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail = 0;

    // SRAM model: byte-laned writes while WE_N low, reads when OE_N low.
    logic [15:0] mem [0:511];
    logic [8:0]  midx;
    assign midx = sram_addr[8:0];
    assign dq = (!ce_n && !oe_n && we_n) ? mem[midx] : 16'bz;
    always @(negedge clk) begin
        if (rst) begin
            mem[9'h20] <= 16'h5678;
            mem[9'h21] <= 16'h1234;
        end else if (!ce_n && !we_n) begin
            if (!lb_n) mem[midx][7:0] <= dq[7:0];
            if (!ub_n) mem[midx][15:8] <= dq[15:8];
        end
    end

    assign dq3 = (!ce3 && !oe3) ? (addr3[15:0] ^ 16'hC3C3) : 16'bz;
    int n3_ce = 0, n3_lo = 0, n3_hi = 0;
    always @(negedge clk) begin
        if (!ce3) begin
            n3_ce++;
            if (addr3 == 18'h12) n3_lo++;
            if (addr3 == 18'h13) n3_hi++;
        end
    end

    typedef struct packed {
        logic [17:0] a;
        logic        we;
        logic        oe;
        logic        lb;
        logic        ub;
        logic [15:0] d;
    } pin_t;
    pin_t plog[$];
    int viol = 0;
    always @(negedge clk) begin
        if (!ce_n) plog.push_back({sram_addr, we_n, oe_n, lb_n, ub_n, dq});
        else if ({oe_n, we_n, lb_n, ub_n} != 4'hF) viol++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        int          id;
        logic [31:0] d;
        int          c;
    } exp_t;
    exp_t sbq[$];

    task automatic sb_pop(input int id, input logic [31:0] d);
        exp_t e;
        if (sbq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_ack: id %0d data %h at cycle %0d, none expected", id, d, cyc);
        end else begin
            e = sbq.pop_front();
            chk("ack_id", id, e.id);
            chk("ack_data", d, e.d);
            chk("ack_cycle", cyc, e.c);
        end
    endtask

    always @(negedge clk) begin
        if (if_ack) sb_pop(0, if_rdata);
        if (ls_ack) sb_pop(1, ls_rdata);
        if (if_ack3) sb_pop(2, if_rdata3);
    end

    logic [31:0] m_if = 32'h0;
    logic [31:0] m_ls = 32'h0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ls_txn(input logic we, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int lat, input logic [31:0] rd,
                          input bit push, input bit scr);
        tick();
        if (push) begin
            if (!we) m_ls = rd;
            sbq.push_back('{1, m_ls, cyc + lat});
        end
        ls_req = 1'b1; ls_we = we; ls_addr = a; ls_wdata = d; ls_strb = s;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (ls_ack) break;
            if (scr && k == 0) begin
                ls_we = ~we; ls_addr = a ^ 32'h100; ls_wdata = ~d; ls_strb = ~s;
            end
        end
        if (!ls_ack) chk("ls_ack_timeout", {31'b0, ls_ack}, 32'd1);
        ls_req = 1'b0;
    endtask

    task automatic if_txn(input logic [31:0] a, input int lat, input logic [31:0] rd,
                          input bit push, input bit scr);
        tick();
        if (push) begin
            m_if = rd;
            sbq.push_back('{0, m_if, cyc + lat});
        end
        if_req = 1'b1; if_addr = a;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (if_ack) break;
            if (scr && k == 0) if_addr = a ^ 32'h100;
        end
        if (!if_ack) chk("if_ack_timeout", {31'b0, if_ack}, 32'd1);
        if_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        rst = 1'b1;
        if_req = 0; if_addr = 0; if_req3 = 0; if_addr3 = 0;
        ls_req = 0; ls_we = 0; ls_addr = 0; ls_wdata = 0; ls_strb = 0;
        repeat (3) tick();
        chk("rst_pins", {24'b0, ce_n, oe_n, we_n, lb_n, ub_n, busy, if_ack, ls_ack},
            32'b1111_1000);
        chk("rst_addr", {14'b0, sram_addr}, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_ls_rdata", ls_rdata, 32'h0);
        rst = 1'b0;
        tick();

        // full write, inputs scrambled after grant
        plog.delete();
        ls_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 5, 32'h0, 1, 1);
        chk("t1_busy_ack", {31'b0, busy}, 32'd1);
        chk("t1_ncyc", plog.size(), 4);
        for (int i = 0; i < 4 && i < plog.size(); i++) begin
            chk("t1_addr", {14'b0, plog[i].a}, 32'h8 + i / 2);
            chk("t1_we", {31'b0, plog[i].we}, i % 2);
            chk("t1_ctl", {29'b0, plog[i].oe, plog[i].lb, plog[i].ub}, 32'b100);
            chk("t1_dq", {16'b0, plog[i].d}, (i < 2) ? 32'hBEEF : 32'hDEAD);
        end

        // full read, upper address bits ignored
        plog.delete();
        if_txn(32'hFFF80010, 5, 32'hDEADBEEF, 1, 1);
        chk("t2_ncyc", plog.size(), 4);
        for (int i = 0; i < 4 && i < plog.size(); i++) begin
            chk("t2_addr", {14'b0, plog[i].a}, 32'h8 + i / 2);
            chk("t2_ctl", {28'b0, plog[i].we, plog[i].oe, plog[i].lb, plog[i].ub}, 32'b1000);
        end
        tick();
        chk("t2_busy_idle", {31'b0, busy}, 32'd0);

        // high-half-only byte write
        plog.delete();
        ls_txn(1'b1, 32'h10, 32'h00AA0000, 4'h4, 3, 32'h0, 1, 1);
        chk("t3_ncyc", plog.size(), 2);
        for (int i = 0; i < 2 && i < plog.size(); i++) begin
            chk("t3_addr", {14'b0, plog[i].a}, 32'h9);
            chk("t3_lanes", {30'b0, plog[i].lb, plog[i].ub}, 32'b01);
            chk("t3_we", {31'b0, plog[i].we}, i);
            chk("t3_dq", {16'b0, plog[i].d}, 32'h00AA);
        end
        ls_txn(1'b0, 32'h10, 32'h0, 4'h0, 5, 32'hDEAABEEF, 1, 1);
        plog.delete();
        ls_txn(1'b1, 32'h10, 32'h12345678, 4'h0, 1, 32'h0, 1, 0);
        chk("t3_strb0_nocyc", plog.size(), 0);
        if_txn(32'h10, 5, 32'hDEAABEEF, 1, 0);

        // continuous contention: LS first, then strict alternation
        s = cyc + 1;
        m_ls = 32'hDEAABEEF;
        m_if = 32'h12345678;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) sbq.push_back('{1, m_ls, s + 5 + 6 * i});
            else sbq.push_back('{0, m_if, s + 5 + 6 * i});
        end
        fork
            begin
                repeat (4) ls_txn(1'b0, 32'h10, 32'h0, 4'hF, 0, 32'h0, 0, 0);
            end
            begin
                repeat (4) if_txn(32'h40, 0, 32'h0, 0, 0);
            end
        join

        // reset in the middle of a write
        tick();
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h20;
        ls_wdata = 32'h11112222; ls_strb = 4'hF;
        tick();
        tick();
        rst = 1'b1;
        ls_req = 1'b0;
        tick();
        chk("t5_pins", {24'b0, ce_n, oe_n, we_n, lb_n, ub_n, busy, if_ack, ls_ack},
            32'b1111_1000);
        chk("t5_addr", {14'b0, sram_addr}, 32'h0);
        chk("t5_if_rdata", if_rdata, 32'h0);
        chk("t5_ls_rdata", ls_rdata, 32'h0);
        rst = 1'b0;
        m_if = 32'h0;
        m_ls = 32'h0;

        // first contention after reset goes to LS
        s = cyc + 1;
        m_ls = 32'h12345678;
        m_if = 32'hDEAABEEF;
        sbq.push_back('{1, m_ls, s + 5});
        sbq.push_back('{0, m_if, s + 11});
        fork
            ls_txn(1'b0, 32'h40, 32'h0, 4'hF, 0, 32'h0, 0, 0);
            if_txn(32'h10, 0, 32'h0, 0, 0);
        join
        if_txn(32'h10, 5, 32'hDEAABEEF, 1, 0);

        // four-cycle phases
        tick();
        n3_ce = 0; n3_lo = 0; n3_hi = 0;
        sbq.push_back('{2, 32'hC3D0C3D1, cyc + 9});
        if_req3 = 1'b1;
        if_addr3 = 32'h24;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (if_ack3) break;
        end
        if (!if_ack3) chk("t6_ack_timeout", {31'b0, if_ack3}, 32'd1);
        if_req3 = 1'b0;
        chk("t6_lo_cycles", n3_lo, 4);
        chk("t6_hi_cycles", n3_hi, 4);
        chk("t6_ce_cycles", n3_ce, 8);

        repeat (3) tick();
        chk("idle_pin_viol", viol, 0);
        chk("sb_leftover", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
